song_recorder: RTL and testbench
================================

# song_recorder

Sequencer for the writing mode of the music box. When enabled, it samples the 16 piano switches on every beat tick and run-length encodes the held key into 12-bit song words. It writes those words into the song register file through write port c (`addr_c`/`data_c`/`wen_c`) and closes each song with an end marker. The playback reader then replays the song from address 0 on port a.

## Interface
Parameters:
- `DEPTH`, 1024: number of song words in the register file. Must be 2..65536. Address `DEPTH-1` is reserved for the end marker.
- `DUR_MAX`, 127: maximum duration in ticks of one word (7-bit field).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: high while the mode controller is in writing mode.
- `start` in 1: one-cycle debounced pulse that begins a recording.
- `stop` in 1: one-cycle debounced pulse that ends a recording.
- `sw` in 16: piano switches. Bit i pressed means key i.
- `beat_tick` in 1: one-cycle pulse at the duration quantum (1/16 beat).
- `addr_c` out 16: register file write address.
- `data_c` out 12: register file write data.
- `wen_c` out 1: register file write enable, one cycle per word.
- `recording` out 1: high in REC.
- `full` out 1: sticky; the song was truncated by capacity.
- `length` out 16: number of note/rest words in the last or current song, excluding the end marker.

## Operation
- **Word format:**
  - `[11]` rest flag.
  - `[10:7]` key index 0..15; 0 when resting.
  - `[6:0]` duration in ticks, 1..DUR_MAX.
  - `12'h000` is the end marker (duration 0).
- **Key code:** the lowest-index set bit of `sw` wins. All switches clear means rest.
- **States:**
  - IDLE → REC on `start` with `enable` high. On entry: `addr` is set to 0, `dur` to 0, `full` to 0, `length` to 0.
  - In REC, on `beat_tick`, sample the key code:
    - `dur==0` (first tick): `cur` becomes the sampled code; `dur` becomes 1.
    - Code equals `cur` and `dur<DUR_MAX`: `dur` increments.
    - Otherwise: write {`cur`,`dur`} at `addr`, increment `addr` and `length`, set `cur` to the sampled code, set `dur` to 1.
    - If that write was at address `DEPTH-2`, set `full` and go to TERM.
  - REC → FLUSH on `stop` or on `enable` low. This takes priority over a same-cycle `beat_tick`; that tick's sample is discarded.
  - FLUSH: if `dur>0`, write {`cur`,`dur`} at `addr` and increment `addr`/`length`. Then go to TERM. If `dur==0`, go straight to TERM.
  - TERM: write `12'h000` at `addr`, then go to IDLE.
  - `start` in any state other than IDLE is ignored.
  - In IDLE, `length` and `full` hold their values.
- **Width rules:** `addr` is counted in 16 bits. `addr` never exceeds `DEPTH-1`. `dur` is 7 bits and saturates by emitting a word at `DUR_MAX`, so the same key held across that boundary produces consecutive equal-key words.
- **Reset:** asserting `rst_n` low mid-recording aborts immediately and writes no end marker. Whatever was previously in memory remains.

## Timing
- All outputs are registered. Reset values: `addr_c`=0, `data_c`=0, `wen_c`=0, `recording`=0, `full`=0, `length`=0, state IDLE.
- `start` to `recording` high: 1 cycle.
- `beat_tick` (change/saturate case) to `wen_c`: 1 cycle. `addr_c`/`data_c` are valid in the same cycle as `wen_c`. `wen_c` is high for exactly 1 cycle.
- `stop` to FLUSH write: 1 cycle. The TERM write follows in the next cycle. Worst case is 2 write cycles back to back at consecutive addresses. `recording` drops in the cycle FLUSH is entered.
- `length` updates in the same cycle as `wen_c` for each note/rest word.
- `beat_tick` is at least 3 cycles apart, so there is never more than one write per tick.

## Structure
- Shared package `musicbox_pkg`:
  - Word field positions (`REST_BIT`, `KEY_MSB/LSB`, `DUR_MSB/LSB`).
  - `END_WORD`=12'h000.
  - Recorder state enum (IDLE, REC, FLUSH, TERM).
- Sub-module `key_encoder`: combinational 16-bit lowest-set-bit priority encoder producing {rest, key[3:0]}. It is reused by the electone display path.
- The FSM, tick handling and address/duration counters live in `song_recorder`.

## Test plan
- **Basic song:** `start`; key 3 held 5 ticks, key 7 held 2 ticks, `stop`. Expect writes: addr 0 = 12'h185, addr 1 = 12'h382, addr 2 = 12'h000. `length`=2; `full`=0.
- **Rest and priority:** `sw`=16'h0000 for 3 ticks, then 16'h0030 for 1 tick, then `stop`. Expect addr 0 = 12'h803 (rest), addr 1 = 12'h201 (key 4 wins over 5), addr 2 = 12'h000.
- **Saturation:** key 0 held 130 ticks, then `stop`. Expect addr 0 = 12'h07F, addr 1 = 12'h003, addr 2 = end marker.
- **Full:** `DEPTH`=4, alternate keys every tick. Expect words at 0..2, end marker at 3, `full`=1, `length`=3, return to IDLE with no `stop` needed.
- **Stop collides with tick:** `stop` and a key-changing `beat_tick` in the same cycle. Expect only the current segment (unchanged `dur`) plus the end marker; the changed key is not recorded.
- **Abort and disable:** (a) `rst_n` low mid-REC: all outputs return to 0 with no further `wen_c`. (b) `enable` low mid-REC: behaves as `stop` (flush write plus end marker).

Source files
------------

// File: rtl/musicbox_pkg.sv
// Shared music-box definitions: song word layout, end marker and recorder states.
package musicbox_pkg;

  localparam int REST_BIT = 11;
  localparam int KEY_MSB  = 10;
  localparam int KEY_LSB  = 7;
  localparam int DUR_MSB  = 6;
  localparam int DUR_LSB  = 0;

  localparam logic [11:0] END_WORD = 12'h000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REC   = 2'd1,
    FLUSH = 2'd2,
    TERM  = 2'd3
  } rec_state_e;

  // code is {rest, key[3:0]} as produced by key_encoder
  function automatic logic [11:0] pack_word(input logic [4:0] code, input logic [6:0] dur);
    logic [11:0] word;
    word                   = END_WORD;
    word[REST_BIT]         = code[4];
    word[KEY_MSB:KEY_LSB]  = code[3:0];
    word[DUR_MSB:DUR_LSB]  = dur;
    return word;
  endfunction

endpackage

// File: rtl/song_recorder_if.sv
// Song register file write port c, driven by the recorder.
interface song_recorder_if;
  logic [15:0] addr_c;
  logic [11:0] data_c;
  logic        wen_c;

  modport master (output addr_c, data_c, wen_c);
  modport slave  (input  addr_c, data_c, wen_c);
endinterface

// File: rtl/key_encoder.sv
// Lowest-set-bit priority encoder for the piano switches; all clear means rest.
module key_encoder (
  input  logic [15:0] sw,
  output logic [4:0]  code
);

  // Scan from the top down so the lowest set bit is the last one to win
  always_comb begin
    code = {1'b1, 4'd0};
    for (int i = 15; i >= 0; i--) begin
      if (sw[i]) begin
        code = {1'b0, 4'(i)};
      end else begin
        code = code;
      end
    end
  end

endmodule

// File: rtl/song_recorder.sv
// Writing-mode sequencer: run-length encodes the held key per beat tick into
// 12-bit song words on write port c and closes each song with an end marker.
module song_recorder
  import musicbox_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int DUR_MAX = 127
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic [15:0]      sw,
  input  logic             beat_tick,
  song_recorder_if.master  wr,
  output logic             recording,
  output logic             full,
  output logic [15:0]      length
);

  localparam logic [15:0] LAST_NOTE = 16'(DEPTH - 2);
  localparam logic [6:0]  DUR_CAP   = 7'(DUR_MAX);

  rec_state_e  state_r, state_s;
  logic [4:0]  cur_r, cur_s, code_s;
  logic [6:0]  dur_r, dur_s;
  logic [15:0] addr_r, addr_s, length_r, length_s;
  logic        full_r, full_s, wen_s, recording_r, wen_c_r;
  logic [11:0] wdata_s, data_c_r;
  logic [15:0] addr_c_r;

  key_encoder u_key_encoder (
    .sw   (sw),
    .code (code_s)
  );

  // Next-state, counter and write-request logic
  always_comb begin
    state_s  = state_r;
    cur_s    = cur_r;
    dur_s    = dur_r;
    addr_s   = addr_r;
    length_s = length_r;
    full_s   = full_r;
    wen_s    = 1'b0;
    wdata_s  = pack_word(cur_r, dur_r);
    case (state_r)
      IDLE: begin
        if (start && enable) begin
          state_s  = REC;
          addr_s   = 16'd0;
          dur_s    = 7'd0;
          full_s   = 1'b0;
          length_s = 16'd0;
        end else begin
          state_s = IDLE;
        end
      end
      REC: begin
        // Stop/disable wins over a coincident tick; that sample is dropped
        if (stop || !enable) begin
          state_s = FLUSH;
        end else if (beat_tick) begin
          if (dur_r == 7'd0) begin
            cur_s = code_s;
            dur_s = 7'd1;
          end else if ((code_s == cur_r) && (dur_r < DUR_CAP)) begin
            dur_s = dur_r + 7'd1;
          end else begin
            wen_s    = 1'b1;
            addr_s   = addr_r + 16'd1;
            length_s = length_r + 16'd1;
            cur_s    = code_s;
            dur_s    = 7'd1;
            if (addr_r == LAST_NOTE) begin
              full_s  = 1'b1;
              state_s = TERM;
            end else begin
              state_s = REC;
            end
          end
        end else begin
          state_s = REC;
        end
      end
      FLUSH: begin
        if (dur_r != 7'd0) begin
          wen_s    = 1'b1;
          addr_s   = addr_r + 16'd1;
          length_s = length_r + 16'd1;
        end else begin
          wen_s = 1'b0;
        end
        dur_s   = 7'd0;
        state_s = TERM;
      end
      TERM: begin
        wen_s   = 1'b1;
        wdata_s = END_WORD;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cur_r       <= 5'd0;
      dur_r       <= 7'd0;
      addr_r      <= 16'd0;
      length_r    <= 16'd0;
      full_r      <= 1'b0;
      recording_r <= 1'b0;
      wen_c_r     <= 1'b0;
      addr_c_r    <= 16'd0;
      data_c_r    <= 12'd0;
    end else begin
      state_r     <= state_s;
      cur_r       <= cur_s;
      dur_r       <= dur_s;
      addr_r      <= addr_s;
      length_r    <= length_s;
      full_r      <= full_s;
      recording_r <= (state_s == REC);
      wen_c_r     <= wen_s;
      if (wen_s) begin
        addr_c_r <= addr_r;
        data_c_r <= wdata_s;
      end
    end
  end

  assign wr.addr_c = addr_c_r;
  assign wr.data_c = data_c_r;
  assign wr.wen_c  = wen_c_r;
  assign recording = recording_r;
  assign full      = full_r;
  assign length    = length_r;

endmodule

// File: tb/tb_song_recorder.sv
// Self-checking bench for song_recorder: table-driven songs plus corner-case
// sequences, with a write scoreboard per DUT instance (DEPTH=1024 and DEPTH=4).
module tb_song_recorder;
  import musicbox_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        stop = 1'b0;
  logic        beat_tick = 1'b0;
  logic [15:0] sw = 16'h0000;
  logic        rec_a, full_a, rec_b, full_b;
  logic [15:0] len_a, len_b;

  song_recorder_if wr_a ();
  song_recorder_if wr_b ();

  song_recorder #(.DEPTH(1024), .DUR_MAX(127)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start_a), .stop(stop),
    .sw(sw), .beat_tick(beat_tick), .wr(wr_a), .recording(rec_a),
    .full(full_a), .length(len_a)
  );

  song_recorder #(.DEPTH(4), .DUR_MAX(127)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start_b), .stop(stop),
    .sw(sw), .beat_tick(beat_tick), .wr(wr_b), .recording(rec_b),
    .full(full_b), .length(len_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [11:0] data;
    logic [15:0] len;
  } wr_t;

  typedef struct {
    logic [15:0] sw_a;
    int          ticks_a;
    logic [15:0] sw_b;
    int          ticks_b;
    logic [11:0] w0;
    logic [11:0] w1;
  } vec_t;

  wr_t  q_a[$];
  wr_t  q_b[$];
  wr_t  ea, eb;
  vec_t vecs[4];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: every write seen on either port must match the queue head
  always @(negedge clk) begin
    if (rst_n && wr_a.wen_c) begin
      if (q_a.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write_a: addr %0h data %0h, none expected", wr_a.addr_c, wr_a.data_c);
      end else begin
        ea = q_a.pop_front();
        check("wr_a_addr", 32'(wr_a.addr_c), 32'(ea.addr));
        check("wr_a_data", 32'(wr_a.data_c), 32'(ea.data));
        check("wr_a_length", 32'(len_a), 32'(ea.len));
      end
    end
    if (rst_n && wr_b.wen_c) begin
      if (q_b.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write_b: addr %0h data %0h, none expected", wr_b.addr_c, wr_b.data_c);
      end else begin
        eb = q_b.pop_front();
        check("wr_b_addr", 32'(wr_b.addr_c), 32'(eb.addr));
        check("wr_b_data", 32'(wr_b.data_c), 32'(eb.data));
        check("wr_b_length", 32'(len_b), 32'(eb.len));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input logic [15:0] addr, input logic [11:0] data, input logic [15:0] len);
    wr_t w;
    w.addr = addr; w.data = data; w.len = len;
    q_a.push_back(w);
  endtask

  task automatic exp_b(input logic [15:0] addr, input logic [11:0] data, input logic [15:0] len);
    wr_t w;
    w.addr = addr; w.data = data; w.len = len;
    q_b.push_back(w);
  endtask

  // One beat tick, then two quiet cycles; checks write latency and pulse width
  task automatic tick(input bit which, input bit expw);
    beat_tick = 1'b1;
    cycle();
    beat_tick = 1'b0;
    if (which) check("tick_wen_b", 32'(wr_b.wen_c), 32'(expw));
    else       check("tick_wen_a", 32'(wr_a.wen_c), 32'(expw));
    cycle();
    if (!which) check("wen_a_one_cycle", 32'(wr_a.wen_c), 32'd0);
    cycle();
  endtask

  task automatic start_rec_a();
    start_a = 1'b1;
    cycle();
    start_a = 1'b0;
    check("rec_after_start", 32'(rec_a), 32'd1);
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("rec_drop_on_stop", 32'(rec_a), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 40) begin
      cycle();
      n++;
    end
    check("drain_queue_empty", 32'(q_a.size() + q_b.size()), 32'd0);
    repeat (3) cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{sw_a:16'h0008, ticks_a:5, sw_b:16'h0080, ticks_b:2,   w0:12'h185, w1:12'h382};
    vecs[1] = '{sw_a:16'h0000, ticks_a:3, sw_b:16'h0030, ticks_b:1,   w0:12'h803, w1:12'h201};
    vecs[2] = '{sw_a:16'hFFFF, ticks_a:1, sw_b:16'h8000, ticks_b:127, w0:12'h001, w1:12'h7FF};
    vecs[3] = '{sw_a:16'h0006, ticks_a:2, sw_b:16'h0000, ticks_b:4,   w0:12'h082, w1:12'h804};

    repeat (3) @(posedge clk);
    #1;
    check("rst_addr_c", 32'(wr_a.addr_c), 32'd0);
    check("rst_data_c", 32'(wr_a.data_c), 32'd0);
    check("rst_wen_c", 32'(wr_a.wen_c), 32'd0);
    check("rst_recording", 32'(rec_a), 32'd0);
    check("rst_full", 32'(full_a), 32'd0);
    check("rst_length", 32'(len_a), 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    cycle();

    for (int i = 0; i < 4; i++) begin
      start_rec_a();
      sw = vecs[i].sw_a;
      repeat (vecs[i].ticks_a) tick(1'b0, 1'b0);
      sw = vecs[i].sw_b;
      exp_a(16'd0, vecs[i].w0, 16'd1);
      tick(1'b0, 1'b1);
      repeat (vecs[i].ticks_b - 1) tick(1'b0, 1'b0);
      exp_a(16'd1, vecs[i].w1, 16'd2);
      exp_a(16'd2, END_WORD, 16'd2);
      stop_pulse();
      drain();
      check("song_length", 32'(len_a), 32'd2);
      check("song_full", 32'(full_a), 32'd0);
    end

    // Saturation: key 0 for 130 ticks
    start_rec_a();
    sw = 16'h0001;
    for (int t = 1; t <= 130; t++) begin
      if (t == 128) exp_a(16'd0, 12'h07F, 16'd1);
      tick(1'b0, t == 128);
    end
    exp_a(16'd1, 12'h003, 16'd2);
    exp_a(16'd2, END_WORD, 16'd2);
    stop_pulse();
    drain();
    check("sat_length", 32'(len_a), 32'd2);

    // Stop collides with a key-changing tick; a start mid-REC is ignored
    start_rec_a();
    sw = 16'h0008;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    start_a = 1'b1;
    cycle();
    start_a = 1'b0;
    tick(1'b0, 1'b0);
    exp_a(16'd0, 12'h183, 16'd1);
    exp_a(16'd1, END_WORD, 16'd1);
    sw = 16'h0080;
    beat_tick = 1'b1;
    stop = 1'b1;
    cycle();
    beat_tick = 1'b0;
    stop = 1'b0;
    check("collide_rec_drop", 32'(rec_a), 32'd0);
    drain();
    check("collide_length", 32'(len_a), 32'd1);

    // Enable low mid-REC acts as stop
    start_rec_a();
    sw = 16'h0004;
    repeat (4) tick(1'b0, 1'b0);
    exp_a(16'd0, 12'h104, 16'd1);
    exp_a(16'd1, END_WORD, 16'd1);
    enable = 1'b0;
    cycle();
    check("disable_rec_drop", 32'(rec_a), 32'd0);
    repeat (3) cycle();
    enable = 1'b1;
    drain();
    check("disable_length", 32'(len_a), 32'd1);

    // Capacity: DEPTH=4 instance, alternating keys, terminates without stop
    start_b = 1'b1;
    cycle();
    start_b = 1'b0;
    check("b_rec_after_start", 32'(rec_b), 32'd1);
    sw = 16'h0001;
    tick(1'b1, 1'b0);
    sw = 16'h0002;
    exp_b(16'd0, 12'h001, 16'd1);
    tick(1'b1, 1'b1);
    sw = 16'h0001;
    exp_b(16'd1, 12'h081, 16'd2);
    tick(1'b1, 1'b1);
    sw = 16'h0002;
    exp_b(16'd2, 12'h001, 16'd3);
    exp_b(16'd3, END_WORD, 16'd3);
    tick(1'b1, 1'b1);
    drain();
    check("b_full", 32'(full_b), 32'd1);
    check("b_length", 32'(len_b), 32'd3);
    check("b_rec_idle", 32'(rec_b), 32'd0);
    sw = 16'h0001;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("b_full_sticky", 32'(full_b), 32'd1);
    check("a_full_clear", 32'(full_a), 32'd0);

    // Reset abort mid-recording
    start_rec_a();
    sw = 16'h0002;
    repeat (3) tick(1'b0, 1'b0);
    sw = 16'h0020;
    exp_a(16'd0, 12'h083, 16'd1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("abort_rec_before", 32'(rec_a), 32'd1);
    rst_n = 1'b0;
    #2;
    check("abort_wen", 32'(wr_a.wen_c), 32'd0);
    check("abort_addr", 32'(wr_a.addr_c), 32'd0);
    check("abort_data", 32'(wr_a.data_c), 32'd0);
    check("abort_rec", 32'(rec_a), 32'd0);
    check("abort_length", 32'(len_a), 32'd0);
    check("abort_full_b", 32'(full_b), 32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (10) cycle();
    check("abort_rec_after", 32'(rec_a), 32'd0);
    check("abort_length_after", 32'(len_a), 32'd0);
    check("abort_queue_empty", 32'(q_a.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
